spi_slave_if: RTL
=================

// Module: spi_slave_if
// PURPOSE
//  SPI responder (slave) for the same 4-wire link driven by the team's SPI master controller.
//  Oversamples sck/cs/mosi in the system clock domain and deserialises MOSI into bytes.
//  Serialises a buffered response byte onto MISO, MSB first, in any of the 4 SPI modes.
//  Sits between the board pins and user logic (register file / loopback test logic).
// PARAMETERS
//  DATA_W   8      bits per SPI word; bit counter width is $clog2(DATA_W)
//  IDLE_TX  8'hFF  word shifted out when no tx word is buffered at word start
// PORTS
//  clk        in   1       system clock; must be >= 4x sck frequency
//  rst_n      in   1       asynchronous, active-low reset
//  mode       in   2       {CPOL,CPHA}; sampled only while cs is inactive
//  sck        in   1       SPI clock from master (asynchronous)
//  cs         in   1       chip select, active low (asynchronous)
//  mosi       in   1       master-out data (asynchronous)
//  miso       out  1       slave-out data
//  miso_oe    out  1       1 = drive miso pin; 0 = release (pin tri-stated outside)
//  tx_data    in   DATA_W  response word
//  tx_valid   in   1       tx_data valid
//  tx_ready   out  1       1-word tx buffer empty; load on tx_valid & tx_ready
//  rx_data    out  DATA_W  received word, held until next rx_valid
//  rx_valid   out  1       1-cycle pulse, rx_data updated this cycle
//  tx_underrun out 1       1-cycle pulse: word start with empty buffer (IDLE_TX used)
//  frame_err  out  1       1-cycle pulse: cs deasserted with partial word
//  busy       out  1       cs active (synchronised)
// BEHAVIOUR
//  - Reset: miso=1, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0,
//    frame_err=0, busy=0, bit_cnt=0, FSM=IDLE, mode latch=2'b00, sync flops=cs 1/sck 0/mosi 0.
//  - sck, cs, mosi pass through 2-flop synchronisers; edges detected on 2nd/3rd flop compare.
//  - Leading edge = rising if CPOL=0 else falling; sample edge = leading if CPHA=0 else
//    trailing; shift edge = the other edge.
//  - FSM IDLE: cs synced high. On cs fall -> LOAD; mode latched.
//  - LOAD (1 clk): shift_tx <= buffer if full (tx_ready->1) else IDLE_TX + tx_underrun pulse;
//    miso <= MSB of loaded word; miso_oe<=1; bit_cnt<=0; -> SHIFT.
//  - SHIFT: on sample edge: shift_rx <= {shift_rx, mosi_s}; bit_cnt++.
//    On shift edge: miso <= next tx bit. CPHA=1: first shift edge must not advance
//    (MSB already on miso), so the first leading edge is ignored for shifting.
//  - Word end: sample edge with bit_cnt==DATA_W-1 -> rx_data<=word, rx_valid pulse next clk,
//    bit_cnt wraps to 0, next tx word loaded as in LOAD (same cycle, no extra state),
//    stay in SHIFT; back-to-back words with cs held low are supported.
//  - rx latency: rx_valid <= 4 clk after the 8th sample edge at the pin.
//  - No rx backpressure: rx_data overwritten each word; user must consume within one word time.
//  - tx buffer write and LOAD in same cycle: LOAD takes the old content; new word is
//    accepted (tx_ready stays 0) for the next word.
//  - cs rise in SHIFT: bit_cnt!=0 -> frame_err pulse, partial word discarded, no rx_valid;
//    any case -> miso_oe<=0, miso<=1, -> IDLE. Buffered tx word is kept.
//  - cs rise and 8th sample edge in same clk: word completes (rx_valid) first, no frame_err.
//  - mode changes while busy are ignored until next cs fall.
//  - rst_n low mid-transfer: all state to reset values immediately; buffered tx word lost.
// STRUCTURE
//  - spi_pkg: SPI_MODE0..3 localparams, state enum {IDLE,LOAD,SHIFT}, CPOL/CPHA bit indices
//    (shared with the master side).
//  - Sub-module spi_in_sync: 2-flop synchroniser + rise/fall pulse outputs, instanced for sck, cs,
//    mosi (mosi uses level only).
// TESTING
//  1 mode 0, cs low, tx 8'h3C preloaded, master sends 8'hA5 -> rx_data=8'hA5 one rx_valid,
//    master reads 8'h3C, tx_ready back to 1 at LOAD.
//  2 modes 1,2,3 same stimulus -> identical rx/tx bytes; MISO stable at every sample edge.
//  3 cs held low, master sends 8'h11,8'h22; tx 8'h80 then 8'h01 -> two rx_valid pulses, master
//    reads 8'h80,8'h01.
//  4 no tx_valid, master clocks one byte -> tx_underrun pulse once, master reads 8'hFF.
//  5 cs rises after 5 bits -> frame_err pulse, no rx_valid, miso_oe=0; next full frame ok.
//  6 rst_n asserted after 3 bits -> all outputs at reset values; next frame 8'h5A received.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: SPI mode encodings, FSM states and mode bit positions shared by master and slave.
package spi_pkg;
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;
    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: 2-flop synchroniser with rise/fall pulses from the 2nd/3rd flop compare.
module spi_in_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [2:0] q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= {3{RST_VAL}};
        else q <= {q[1:0], d};

    assign level = q[1];
    assign rise  = q[1] & ~q[2];
    assign fall  = ~q[1] & q[2];
endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: oversampling SPI responder, all 4 modes, MSB first, 1-word tx buffer.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int               DATA_W  = 8,
    parameter logic [DATA_W-1:0] IDLE_TX = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              sck,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_err,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W);

    state_t            state, state_nx;
    logic              sck_s, sck_r, sck_f, cs_s, cs_r, cs_f, mosi_s;
    logic              unused_sck_level, unused_mosi_rise, unused_mosi_fall;
    logic [1:0]        mode_q;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-2:0] shift_rx, shift_tx;
    logic [DATA_W-1:0] tx_buf, next_word;
    logic              und_pend, lead, trail, sample, shift_e, word_end, load;

    spi_in_sync #(.RST_VAL(1'b0)) u_sck  (.clk(clk), .rst_n(rst_n), .d(sck),  .level(unused_sck_level), .rise(sck_r), .fall(sck_f));
    spi_in_sync #(.RST_VAL(1'b1)) u_cs   (.clk(clk), .rst_n(rst_n), .d(cs),   .level(cs_s), .rise(cs_r), .fall(cs_f));
    spi_in_sync #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .level(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

    assign lead      = mode_q[CPOL_BIT] ? sck_f : sck_r;
    assign trail     = mode_q[CPOL_BIT] ? sck_r : sck_f;
    assign sample    = mode_q[CPHA_BIT] ? trail : lead;
    assign shift_e   = mode_q[CPHA_BIT] ? lead : trail;
    assign word_end  = state == SHIFT && sample && bit_cnt == CW'(DATA_W - 1);
    assign load      = state == LOAD || (word_end && !cs_r);
    assign next_word = tx_ready ? IDLE_TX : tx_buf;
    assign busy      = ~cs_s;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE && cs_f) ? LOAD :
                   (state == LOAD) ? SHIFT :
                   (state == SHIFT && cs_r) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso        <= 1'b1;
            miso_oe     <= 1'b0;
            tx_ready    <= 1'b1;
            tx_buf      <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            bit_cnt     <= '0;
            mode_q      <= 2'b00;
            shift_rx    <= '0;
            shift_tx    <= '0;
            und_pend    <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            if (state == IDLE && cs_f) mode_q <= mode;
            // a write racing a load fills the buffer for the following word
            if (tx_valid && tx_ready) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end else if (load && !tx_ready) tx_ready <= 1'b1;
            if (load) begin
                shift_tx <= next_word[DATA_W-2:0];
                miso     <= next_word[DATA_W-1];
                miso_oe  <= 1'b1;
            end
            if (state == LOAD) begin
                tx_underrun <= tx_ready;
                bit_cnt     <= '0;
                und_pend    <= 1'b0;
            end
            if (state == SHIFT) begin
                if (sample) begin
                    shift_rx <= {shift_rx[DATA_W-3:0], mosi_s};
                    bit_cnt  <= word_end ? '0 : bit_cnt + 1'b1;
                end
                if (word_end) begin
                    rx_data  <= {shift_rx, mosi_s};
                    rx_valid <= 1'b1;
                end
                // underrun from a word-end load is only reported once that word actually starts
                if (word_end && !cs_r) und_pend <= tx_ready;
                if (sample && bit_cnt == '0 && und_pend) begin
                    tx_underrun <= 1'b1;
                    und_pend    <= 1'b0;
                end
                // bit_cnt==0 shift edge would clobber a freshly loaded MSB
                if (shift_e && bit_cnt != '0) begin
                    miso     <= shift_tx[DATA_W-2];
                    shift_tx <= {shift_tx[DATA_W-3:0], 1'b0};
                end
                if (cs_r) begin
                    frame_err <= (bit_cnt != '0 || sample) && !word_end;
                    miso_oe   <= 1'b0;
                    miso      <= 1'b1;
                    bit_cnt   <= '0;
                    und_pend  <= 1'b0;
                end
            end
        end
    end
endmodule
